// File: rtl/fifo_defines_pkg.sv
// fifo_defines_pkg: shared FIFO sample width, reader FSM states and DAC SPI framing constants
package fifo_defines_pkg;
   localparam int DATA_WIDTH = 16;
   // SPI mode 0: sclk idles low, DAC samples on the rising edge, MSB goes out first
   localparam bit SPI_CPOL      = 1'b0;
   localparam bit SPI_MSB_FIRST = 1'b1;
   typedef enum logic [2:0] {IDLE, REQ, CAPT, SHIFT, GAP} reader_state_e;
endpackage

// File: rtl/reader_tick_gen.sv
// reader_tick_gen: sample-period counter producing a one-cycle tick every SAMPLE_PERIOD enabled cycles
//   clk, rst : clock, async active-high reset
//   en_i     : count enable; while low the counter is parked at SAMPLE_PERIOD-1
//   tick_o   : high for the cycle in which the counter sits at zero with en_i high
module reader_tick_gen #(
   parameter int SAMPLE_PERIOD = 256
) (
   input  logic clk,
   input  logic rst,
   input  logic en_i,
   output logic tick_o
);
   localparam int CW = (SAMPLE_PERIOD > 2) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam logic [CW-1:0] RELOAD = CW'(SAMPLE_PERIOD - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   assign tick_o = en_i && (cnt_q == '0);
   // parking at RELOAD while disabled makes the first tick land a full period after enable
   always_comb cnt_d = (!en_i || tick_o) ? RELOAD : cnt_q - 1'b1;
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt_q <= RELOAD;
      else     cnt_q <= cnt_d;
endmodule

// File: rtl/fifo_sample_reader.sv
// fifo_sample_reader: pops one FIFO sample per period and shifts it out on an SPI mode-0 DAC link
//   clk, rst        : clock, async active-high reset
//   en_i            : playback enable
//   fifo_empty_i    : FIFO empty flag
//   fifo_data_i     : FIFO read data, valid the cycle after rd_en_o
//   rd_en_o         : one-cycle FIFO pop strobe
//   cs_n_o, sclk_o, sdata_o : DAC chip select, serial clock, serial data
//   busy_o          : frame in progress (REQ through GAP)
//   frame_done_o    : one-cycle pulse after the last falling sclk edge
//   underrun_cnt_o  : saturating count of empty-FIFO ticks when READER_UNDERRUN_EN is defined, else 0
module fifo_sample_reader #(
   parameter int DATA_WIDTH    = fifo_defines_pkg::DATA_WIDTH,
   parameter int CLK_DIV       = 4,
   parameter int SAMPLE_PERIOD = 256
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en_i,
   input  logic                         fifo_empty_i,
   input  logic signed [DATA_WIDTH-1:0] fifo_data_i,
   output logic                         rd_en_o,
   output logic                         cs_n_o,
   output logic                         sclk_o,
   output logic                         sdata_o,
   output logic                         busy_o,
   output logic                         frame_done_o,
   output logic [15:0]                  underrun_cnt_o
);
   import fifo_defines_pkg::*;

   if (CLK_DIV < 1 || SAMPLE_PERIOD < 2*CLK_DIV*(DATA_WIDTH+1)+4) begin : g_bad_params
      $error("fifo_sample_reader: SAMPLE_PERIOD too short for one frame plus gap");
   end

   localparam int DIV_W = (2*CLK_DIV > 1) ? $clog2(2*CLK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2*CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

   reader_state_e         state_q;
   logic [DATA_WIDTH-1:0] sh_q;
   logic [DIV_W-1:0]      div_q;
   logic [BIT_W-1:0]      bit_q;
   logic                  rd_en_q, cs_n_q, sclk_q, sdata_q, busy_q, done_q;
   logic                  tick;

   reader_tick_gen #(.SAMPLE_PERIOD(SAMPLE_PERIOD)) u_tick (
      .clk    (clk),
      .rst    (rst),
      .en_i   (en_i),
      .tick_o (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sh_q    <= '0;
         div_q   <= '0;
         bit_q   <= '0;
         rd_en_q <= 1'b0;
         cs_n_q  <= 1'b1;
         sclk_q  <= SPI_CPOL;
         sdata_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         rd_en_q <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: if (tick && !fifo_empty_i) begin
               state_q <= REQ;
               rd_en_q <= 1'b1;
               busy_q  <= 1'b1;
            end
            REQ: state_q <= CAPT;
            CAPT: begin
               sh_q    <= fifo_data_i;
               sdata_q <= SPI_MSB_FIRST ? fifo_data_i[DATA_WIDTH-1] : fifo_data_i[0];
               cs_n_q  <= 1'b0;
               div_q   <= '0;
               bit_q   <= '0;
               state_q <= SHIFT;
            end
            SHIFT: begin
               div_q <= div_q + 1'b1;
               if (div_q == DIV_HALF) sclk_q <= ~SPI_CPOL;
               if (div_q == DIV_LAST) begin
                  div_q  <= '0;
                  sclk_q <= SPI_CPOL;
                  if (bit_q == BIT_LAST) begin
                     done_q  <= 1'b1;
                     cs_n_q  <= 1'b1;
                     state_q <= GAP;
                  end else begin
                     // next bit is presented on the falling edge so it is stable for the next rise
                     bit_q   <= bit_q + 1'b1;
                     sh_q    <= SPI_MSB_FIRST ? {sh_q[DATA_WIDTH-2:0], 1'b0} : {1'b0, sh_q[DATA_WIDTH-1:1]};
                     sdata_q <= SPI_MSB_FIRST ? sh_q[DATA_WIDTH-2] : sh_q[1];
                  end
               end
            end
            GAP: begin
               div_q <= div_q + 1'b1;
               if (div_q == DIV_LAST) begin
                  div_q   <= '0;
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rd_en_o      = rd_en_q;
   assign cs_n_o       = cs_n_q;
   assign sclk_o       = sclk_q;
   assign sdata_o      = sdata_q;
   assign busy_o       = busy_q;
   assign frame_done_o = done_q;

`ifdef READER_UNDERRUN_EN
   logic [15:0] und_q;
   always_ff @(posedge clk or posedge rst)
      if (rst)                                       und_q <= '0;
      else if (tick && fifo_empty_i && und_q != '1)  und_q <= und_q + 1'b1;
   assign underrun_cnt_o = und_q;
`else
   assign underrun_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fifo_sample_reader.sv
// tb_fifo_sample_reader: directed self-checking bench for fifo_sample_reader (default and CLK_DIV=1 builds)
module tb_fifo_sample_reader;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1, en = 1'b0, empty = 1'b1;
   logic [15:0] data = '0;
   logic        rd, cs_n, sclk, sd, busy, done;
   logic [15:0] und;
   logic        rst6 = 1'b1, en6 = 1'b0, empty6 = 1'b1;
   logic [15:0] data6 = '0;
   logic        rd6, cs6, sclk6, sd6, busy6, done6;
   logic [15:0] und6;

   int tests = 0, fails = 0, ncyc = 0, bad_tick = 0;

`ifdef READER_UNDERRUN_EN
   localparam int EXP_UND = 3;
`else
   localparam int EXP_UND = 0;
`endif

   fifo_sample_reader dut (
      .clk(clk), .rst(rst), .en_i(en), .fifo_empty_i(empty), .fifo_data_i(data),
      .rd_en_o(rd), .cs_n_o(cs_n), .sclk_o(sclk), .sdata_o(sd), .busy_o(busy),
      .frame_done_o(done), .underrun_cnt_o(und)
   );

   fifo_sample_reader #(.CLK_DIV(1), .SAMPLE_PERIOD(40)) dut6 (
      .clk(clk), .rst(rst6), .en_i(en6), .fifo_empty_i(empty6), .fifo_data_i(data6),
      .rd_en_o(rd6), .cs_n_o(cs6), .sclk_o(sclk6), .sdata_o(sd6), .busy_o(busy6),
      .frame_done_o(done6), .underrun_cnt_o(und6)
   );

   always @(posedge clk) ncyc <= ncyc + 1;

   // a tick while a frame is in flight would mean the period rule failed to hold
   always @(negedge clk) begin
      if (dut.tick && busy)   bad_tick++;
      if (dut6.tick && busy6) bad_tick++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_rd(input bit s, input int budget, output int t, output bit got);
      got = 1'b0;
      t = 0;
      for (int i = 0; i < budget && !got; i++) begin
         @(negedge clk);
         if (s ? rd6 : rd) begin
            got = 1'b1;
            t = ncyc;
         end
      end
   endtask

   // starts on the sample where rd_en was seen; walks the frame until busy drops
   task automatic frame(input string tag, input bit s, input int drop_at, input logic [15:0] exp_bits,
                        input int exp_len, input int exp_gap, input int exp_hi);
      int idx = 0, done_idx = 0, run = 0, rises = 0, cs_idx = -1, dones = 0, hi_max = 0;
      logic prev = 1'b0, b, c, k, q, d;
      logic [15:0] bits = '0;
      b = s ? busy6 : busy;
      while (b && idx < 1000) begin
         c = s ? cs6 : cs_n;
         k = s ? sclk6 : sclk;
         q = s ? sd6 : sd;
         d = s ? done6 : done;
         if (cs_idx < 0 && !c) cs_idx = idx;
         if (k && !prev) begin
            rises++;
            bits = {bits[14:0], q};
         end
         run = k ? run + 1 : 0;
         if (run > hi_max) hi_max = run;
         if (d) begin
            dones++;
            done_idx = idx;
         end
         if (idx == drop_at) en = 1'b0;
         prev = k;
         idx++;
         @(negedge clk);
         b = s ? busy6 : busy;
      end
      chk({tag, "_bits"}, bits, exp_bits);
      chk({tag, "_rises"}, rises, 16);
      chk({tag, "_cs_lat"}, cs_idx, 2);
      chk({tag, "_len"}, idx, exp_len);
      chk({tag, "_done_cnt"}, dones, 1);
      chk({tag, "_gap"}, idx - done_idx, exp_gap);
      chk({tag, "_sclk_hi"}, hi_max, exp_hi);
      chk({tag, "_cs_idle"}, s ? cs6 : cs_n, 1);
   endtask

   initial begin
      int r, t, t0, nrd, ncs;
      bit got;
      repeat (3) @(negedge clk);
      chk("rst_rd", rd, 0);
      chk("rst_cs_n", cs_n, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_sdata", sd, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_und", und, 0);
      chk("rst_period", dut.u_tick.cnt_q, 255);
      chk("rst6_cs_n", cs6, 1);

      data = 16'hA55A; empty = 1'b0; rst = 1'b0; en = 1'b1; r = ncyc;
      wait_rd(0, 300, t, got);
      chk("t1_rd_seen", got, 1);
      chk("t1_rd_latency", t - r, 256);
      frame("t1", 0, -1, 16'hA55A, 138, 8, 4);
      t0 = t;

      data = 16'h8001;
      wait_rd(0, 300, t, got);
      chk("t2a_period", t - t0, 256);
      frame("t2a", 0, -1, 16'h8001, 138, 8, 4);
      t0 = t;
      data = 16'h7FFF;
      wait_rd(0, 300, t, got);
      chk("t2b_period", t - t0, 256);
      frame("t2b", 0, -1, 16'h7FFF, 138, 8, 4);
      t0 = t;

      empty = 1'b1; nrd = 0; ncs = 0;
      while (ncyc < t0 + 790) begin
         @(negedge clk);
         if (rd) nrd++;
         if (!cs_n) ncs++;
      end
      chk("t3_no_rd", nrd, 0);
      chk("t3_cs_high", ncs, 0);
      chk("t3_underrun", und, EXP_UND);
      empty = 1'b0; data = 16'h1234;
      wait_rd(0, 300, t, got);
      chk("t3_resume", t - t0, 1024);

      frame("t4", 0, 22, 16'h1234, 138, 8, 4);
      chk("t4_en_low", en, 0);
      wait_rd(0, 400, t, got);
      chk("t4_no_rd", got, 0);
      chk("t4_period_held", dut.u_tick.cnt_q, 255);

      data = 16'h0F0F; en = 1'b1; r = ncyc;
      wait_rd(0, 300, t, got);
      chk("t5_rd_latency", t - r, 256);
      repeat (20) @(negedge clk);
      for (int i = 0; i < 20 && !sclk; i++) @(negedge clk);
      chk("t5_pre_sclk", sclk, 1);
      chk("t5_pre_cs_n", cs_n, 0);
      rst = 1'b1;
      #1;
      chk("t5_rst_cs_n", cs_n, 1);
      chk("t5_rst_sclk", sclk, 0);
      chk("t5_rst_busy", busy, 0);
      @(negedge clk);
      rst = 1'b0; data = 16'hF00F; r = ncyc;
      wait_rd(0, 300, t, got);
      chk("t5_full_period", t - r, 256);
      chk("t5_und_cleared", und, 0);
      frame("t5", 0, -1, 16'hF00F, 138, 8, 4);

      data6 = 16'hC3A5; empty6 = 1'b0; rst6 = 1'b0; en6 = 1'b1; r = ncyc;
      wait_rd(1, 100, t, got);
      chk("t6_rd_latency", t - r, 40);
      frame("t6a", 1, -1, 16'hC3A5, 36, 2, 1);
      t0 = t;
      data6 = 16'h5A3C;
      wait_rd(1, 100, t, got);
      chk("t6_period", t - t0, 40);
      frame("t6b", 1, -1, 16'h5A3C, 36, 2, 1);

      chk("no_tick_outside_idle", bad_tick, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
